// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the RV32I hazard controller: forwarding selects,
// sequencer state encoding and the forwarding priority function.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_MW = 2'b01;
   localparam logic [1:0] FWD_EM = 2'b10;

   typedef enum logic {
      HZ_RUN     = 1'b0,
      HZ_MC_WAIT = 1'b1
   } hz_state_t;

   // EX/MEM result is younger than MEM/WB, so it is checked first.
   function automatic logic [1:0] fwd_sel(
      input logic       we_em,
      input logic [4:0] rd_em,
      input logic       we_mw,
      input logic [4:0] rd_mw,
      input logic [4:0] rs
   );
      if (we_em && (rd_em != 5'd0) && (rd_em == rs))
         return FWD_EM;
      else if (we_mw && (rd_mw != 5'd0) && (rd_mw == rs))
         return FWD_MW;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_mc_seq.sv
// Multi-cycle EX sequencer: holds the front end while a long EX op runs and
// pulses done in the op's final EX cycle.
module mc_seq
   import hazard_ctrl_pkg::*;
#(
   parameter int MC_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic done,
   output logic waiting
);

   // The cycle in which the op enters EX already counts as the first one.
   localparam logic [7:0] CNT_LOAD = (MC_CYCLES > 1) ? 8'(MC_CYCLES - 2) : 8'd0;

   hz_state_t  state, state_nxt;
   logic [7:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= HZ_RUN;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         HZ_RUN: begin
            if (start) begin
               if (MC_CYCLES > 1) begin
                  busy      = 1'b1;
                  state_nxt = HZ_MC_WAIT;
                  cnt_nxt   = CNT_LOAD;
               end else begin
                  done = 1'b1;
               end
            end
         end
         HZ_MC_WAIT: begin
            if (cnt != 8'd0) begin
               busy    = 1'b1;
               cnt_nxt = cnt - 8'd1;
            end else begin
               done      = 1'b1;
               state_nxt = HZ_RUN;
            end
         end
         default: state_nxt = HZ_RUN;
      endcase
   end

   assign waiting = (state == HZ_MC_WAIT);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use stall, branch flush and
// multi-cycle stall sequencing. Define HAZARD_PERF_EN to build the perf counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MC_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  RS1_D,
   input  logic [4:0]  RS2_D,
   input  logic        USE_RS1_D,
   input  logic        USE_RS2_D,
   input  logic [4:0]  RS1_DE,
   input  logic [4:0]  RS2_DE,
   input  logic [4:0]  RD_DE,
   input  logic        MemRead_DE,
   input  logic        MultiCyc_DE,
   input  logic [4:0]  RD_EM,
   input  logic        RegWrite_EM,
   input  logic [4:0]  RD_MW,
   input  logic        RegWrite_MW,
   input  logic        isBranch_E,
   output logic [1:0]  ForwardA,
   output logic [1:0]  ForwardB,
   output logic        STALL_F,
   output logic        STALL_D,
   output logic        STALL_E,
   output logic        FLUSH_D,
   output logic        FLUSH_E,
   output logic        BUBBLE_M,
   output logic        MC_BUSY,
   output logic        MC_DONE,
   output logic [31:0] PERF_STALL,
   output logic [31:0] PERF_FLUSH,
   output logic [31:0] PERF_LU
);

   logic lu, lu_stall;
   logic mc_busy, mc_done, mc_wait;

   mc_seq #(.MC_CYCLES(MC_CYCLES)) u_mc_seq (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (MultiCyc_DE),
      .busy    (mc_busy),
      .done    (mc_done),
      .waiting (mc_wait)
   );

   assign lu = MemRead_DE && (RD_DE != 5'd0) &&
               ((USE_RS1_D && (RD_DE == RS1_D)) || (USE_RS2_D && (RD_DE == RS2_D)));

   // Every output is forced quiet while reset is held, including the
   // purely combinational paths.
   always_comb begin
      ForwardA = FWD_RF;
      ForwardB = FWD_RF;
      STALL_F  = 1'b0;
      STALL_D  = 1'b0;
      STALL_E  = 1'b0;
      FLUSH_D  = 1'b0;
      FLUSH_E  = 1'b0;
      BUBBLE_M = 1'b0;
      MC_BUSY  = 1'b0;
      MC_DONE  = 1'b0;
      lu_stall = 1'b0;
      if (rst_n) begin
         ForwardA = fwd_sel(RegWrite_EM, RD_EM, RegWrite_MW, RD_MW, RS1_DE);
         ForwardB = fwd_sel(RegWrite_EM, RD_EM, RegWrite_MW, RD_MW, RS2_DE);
         MC_BUSY  = mc_busy;
         MC_DONE  = mc_done;
         if (mc_busy) begin
            STALL_F  = 1'b1;
            STALL_D  = 1'b1;
            STALL_E  = 1'b1;
            BUBBLE_M = 1'b1;
         end else if (!mc_wait) begin
            if (isBranch_E) begin
               FLUSH_D = 1'b1;
               FLUSH_E = 1'b1;
            end else if (lu) begin
               STALL_F  = 1'b1;
               STALL_D  = 1'b1;
               FLUSH_E  = 1'b1;
               lu_stall = 1'b1;
            end
         end
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PERF_STALL <= 32'd0;
         PERF_FLUSH <= 32'd0;
         PERF_LU    <= 32'd0;
      end else begin
         PERF_STALL <= PERF_STALL + {31'd0, STALL_F};
         PERF_FLUSH <= PERF_FLUSH + {31'd0, FLUSH_D};
         PERF_LU    <= PERF_LU + {31'd0, lu_stall};
      end
   end
`else
   assign PERF_STALL = 32'd0;
   assign PERF_FLUSH = 32'd0;
   assign PERF_LU    = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MC_CYCLES=4; works with or without
// HAZARD_PERF_EN.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  RS1_D, RS2_D, RS1_DE, RS2_DE, RD_DE, RD_EM, RD_MW;
   logic        USE_RS1_D, USE_RS2_D, MemRead_DE, MultiCyc_DE;
   logic        RegWrite_EM, RegWrite_MW, isBranch_E;
   logic [1:0]  ForwardA, ForwardB;
   logic        STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, BUBBLE_M, MC_BUSY, MC_DONE;
   logic [31:0] PERF_STALL, PERF_FLUSH, PERF_LU;

   int n_cmp = 0;
   int n_err = 0;

`ifdef HAZARD_PERF_EN
   localparam logic [31:0] EXP_STALL = 32'd7;
   localparam logic [31:0] EXP_FLUSH = 32'd1;
   localparam logic [31:0] EXP_LU    = 32'd1;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
   localparam logic [31:0] EXP_FLUSH = 32'd0;
   localparam logic [31:0] EXP_LU    = 32'd0;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.MC_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .RS1_D(RS1_D), .RS2_D(RS2_D), .USE_RS1_D(USE_RS1_D), .USE_RS2_D(USE_RS2_D),
      .RS1_DE(RS1_DE), .RS2_DE(RS2_DE), .RD_DE(RD_DE),
      .MemRead_DE(MemRead_DE), .MultiCyc_DE(MultiCyc_DE),
      .RD_EM(RD_EM), .RegWrite_EM(RegWrite_EM), .RD_MW(RD_MW), .RegWrite_MW(RegWrite_MW),
      .isBranch_E(isBranch_E),
      .ForwardA(ForwardA), .ForwardB(ForwardB),
      .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E),
      .FLUSH_D(FLUSH_D), .FLUSH_E(FLUSH_E), .BUBBLE_M(BUBBLE_M),
      .MC_BUSY(MC_BUSY), .MC_DONE(MC_DONE),
      .PERF_STALL(PERF_STALL), .PERF_FLUSH(PERF_FLUSH), .PERF_LU(PERF_LU)
   );

   // Inputs change 2 time units after a rising edge; outputs are read 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      RS1_D = 0; RS2_D = 0; USE_RS1_D = 0; USE_RS2_D = 0;
      RS1_DE = 0; RS2_DE = 0; RD_DE = 0; MemRead_DE = 0; MultiCyc_DE = 0;
      RD_EM = 0; RegWrite_EM = 0; RD_MW = 0; RegWrite_MW = 0; isBranch_E = 0;
   endtask

   task automatic test_reset();
      logic [9:0] ctl;
      rst_n = 1'b0;
      clear_inputs();
      MultiCyc_DE = 1'b1; RegWrite_EM = 1'b1; RD_EM = 5'd3; RS1_DE = 5'd3;
      #12;
      ctl = {STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E, BUBBLE_M, MC_BUSY, MC_DONE, ForwardA[1], ForwardA[0]};
      n_cmp++; if (ctl !== 10'd0) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, 10'd0); end
      n_cmp++; if ({PERF_STALL, PERF_FLUSH, PERF_LU} !== 96'd0) begin n_err++; $display("FAIL reset_perf: got %0d/%0d/%0d want 0/0/0", PERF_STALL, PERF_FLUSH, PERF_LU); end
      clear_inputs();
      tick();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (MC_BUSY !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", MC_BUSY); end
   endtask

   task automatic test_forwarding();
      clear_inputs();
      RD_EM = 5'd5; RegWrite_EM = 1'b1; RD_MW = 5'd5; RegWrite_MW = 1'b1; RS1_DE = 5'd5; RS2_DE = 5'd0;
      #1;
      n_cmp++; if (ForwardA !== 2'b10) begin n_err++; $display("FAIL fwdA_em_prio: got %b want 10", ForwardA); end
      n_cmp++; if (ForwardB !== 2'b00) begin n_err++; $display("FAIL fwdB_x0: got %b want 00", ForwardB); end
      RD_EM = 5'd0;
      #1;
      n_cmp++; if (ForwardA !== 2'b01) begin n_err++; $display("FAIL fwdA_em_x0: got %b want 01", ForwardA); end
      RD_EM = 5'd9; RS2_DE = 5'd9; RegWrite_MW = 1'b0;
      #1;
      n_cmp++; if (ForwardB !== 2'b10) begin n_err++; $display("FAIL fwdB_em: got %b want 10", ForwardB); end
      n_cmp++; if (ForwardA !== 2'b00) begin n_err++; $display("FAIL fwdA_mw_nowe: got %b want 00", ForwardA); end
      RegWrite_EM = 1'b0; RegWrite_MW = 1'b1; RD_MW = 5'd9;
      #1;
      n_cmp++; if (ForwardB !== 2'b01) begin n_err++; $display("FAIL fwdB_mw: got %b want 01", ForwardB); end
      clear_inputs();
   endtask

   task automatic test_load_use();
      logic [2:0] v;
      clear_inputs();
      MemRead_DE = 1'b1; RD_DE = 5'd7; RS2_D = 5'd7; USE_RS2_D = 1'b1; RS1_D = 5'd2; USE_RS1_D = 1'b1;
      #1;
      v = {STALL_F, STALL_D, FLUSH_E};
      n_cmp++; if (v !== 3'b111) begin n_err++; $display("FAIL lu_stall: got %b want 111", v); end
      n_cmp++; if ({STALL_E, FLUSH_D} !== 2'b00) begin n_err++; $display("FAIL lu_other: got %b want 00", {STALL_E, FLUSH_D}); end
      tick();
      USE_RS2_D = 1'b0;
      #1;
      v = {STALL_F, STALL_D, FLUSH_E};
      n_cmp++; if (v !== 3'b000) begin n_err++; $display("FAIL lu_unused_rs2: got %b want 000", v); end
      USE_RS2_D = 1'b1; RD_DE = 5'd0; RS2_D = 5'd0;
      #1;
      n_cmp++; if (STALL_F !== 1'b0) begin n_err++; $display("FAIL lu_x0: got %b want 0", STALL_F); end
      tick();
      clear_inputs();
   endtask

   task automatic test_branch();
      logic [3:0] v;
      clear_inputs();
      MemRead_DE = 1'b1; RD_DE = 5'd7; RS1_D = 5'd7; USE_RS1_D = 1'b1; isBranch_E = 1'b1;
      #1;
      v = {FLUSH_D, FLUSH_E, STALL_F, STALL_D};
      n_cmp++; if (v !== 4'b1100) begin n_err++; $display("FAIL branch_lu: got %b want 1100", v); end
      tick();
      clear_inputs();
   endtask

   task automatic test_multicycle();
      logic [4:0] v;
      clear_inputs();
      MultiCyc_DE = 1'b1;
      // Two ops back to back: each stalls 3 cycles and completes in its 4th.
      for (int op = 0; op < 2; op++) begin
         for (int c = 1; c <= 4; c++) begin
            if (c == 3) begin MemRead_DE = 1'b1; RD_DE = 5'd4; RS1_D = 5'd4; USE_RS1_D = 1'b1; end
            #1;
            v = {STALL_F, STALL_D, STALL_E, BUBBLE_M, MC_BUSY};
            n_cmp++; if (v !== ((c < 4) ? 5'b11111 : 5'b00000)) begin n_err++; $display("FAIL mc_op%0d_c%0d_stall: got %b want %b", op, c, v, (c < 4) ? 5'b11111 : 5'b00000); end
            n_cmp++; if (MC_DONE !== (c == 4)) begin n_err++; $display("FAIL mc_op%0d_c%0d_done: got %b want %b", op, c, MC_DONE, c == 4); end
            if (c == 3) begin
               n_cmp++; if (FLUSH_E !== 1'b0) begin n_err++; $display("FAIL mc_lu_masked: got %b want 0", FLUSH_E); end
               MemRead_DE = 1'b0; RD_DE = 5'd0; RS1_D = 5'd0; USE_RS1_D = 1'b0;
            end
            tick();
         end
      end
      MultiCyc_DE = 1'b0;
      #1;
      n_cmp++; if ({STALL_F, MC_BUSY, MC_DONE} !== 3'b000) begin n_err++; $display("FAIL mc_idle: got %b want 000", {STALL_F, MC_BUSY, MC_DONE}); end
   endtask

   task automatic test_perf();
      n_cmp++; if (PERF_STALL !== EXP_STALL) begin n_err++; $display("FAIL perf_stall: got %0d want %0d", PERF_STALL, EXP_STALL); end
      n_cmp++; if (PERF_FLUSH !== EXP_FLUSH) begin n_err++; $display("FAIL perf_flush: got %0d want %0d", PERF_FLUSH, EXP_FLUSH); end
      n_cmp++; if (PERF_LU !== EXP_LU) begin n_err++; $display("FAIL perf_lu: got %0d want %0d", PERF_LU, EXP_LU); end
   endtask

   task automatic test_reset_mid();
      clear_inputs();
      MultiCyc_DE = 1'b1;
      tick();
      #1;
      n_cmp++; if (MC_BUSY !== 1'b1) begin n_err++; $display("FAIL rmid_busy_cnt2: got %b want 1", MC_BUSY); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({STALL_F, STALL_D, STALL_E, BUBBLE_M, MC_BUSY, MC_DONE} !== 6'd0) begin n_err++; $display("FAIL rmid_outputs: got %b want 000000", {STALL_F, STALL_D, STALL_E, BUBBLE_M, MC_BUSY, MC_DONE}); end
      n_cmp++; if (PERF_STALL !== 32'd0) begin n_err++; $display("FAIL rmid_perf: got %0d want 0", PERF_STALL); end
      MultiCyc_DE = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      n_cmp++; if ({STALL_F, MC_BUSY, MC_DONE} !== 3'b000) begin n_err++; $display("FAIL rmid_release: got %b want 000", {STALL_F, MC_BUSY, MC_DONE}); end
      tick();
      #1;
      n_cmp++; if ({STALL_F, MC_BUSY, MC_DONE} !== 3'b000) begin n_err++; $display("FAIL rmid_run: got %b want 000", {STALL_F, MC_BUSY, MC_DONE}); end
      // A fresh op must start from RUN with the full occupancy.
      MultiCyc_DE = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         #1;
         n_cmp++; if (MC_DONE !== (c == 4)) begin n_err++; $display("FAIL rmid_restart_c%0d: got %b want %b", c, MC_DONE, c == 4); end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      fork
         begin
            #20000;
            $display("FAIL watchdog: got timeout want completion");
            $fatal(1, "bench timed out");
         end
      join_none
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_multicycle();
      test_perf();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
